mfc_mean_sub: RTL and testbench

Streaming mean-subtraction stage that sits directly downstream of the 24-entry MFC coefficient table RAM. It accepts one 24-word feature frame at a time over a valid/ready handshake and drives the table's address port so each word is paired with its stored constant. Each result is (feature − constant) >>> SHIFT, saturated to OWIDTH, and forwarded to the DNN input layer with an end-of-frame marker. Between frames it can also reload the table sequentially.

---
 rtl/mfc_pkg.sv | 41 ++++
 rtl/mfc_mean_sub_if.sv | 25 ++
 rtl/mfc_sat_shift.sv | 26 ++
 rtl/mfc_mean_sub.sv | 126 ++++++++++++
 tb/tb_mfc_mean_sub.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mfc_pkg.sv
// mfc_pkg: shared FSM encoding, default geometry and saturation helper
// for the MFC mean-subtraction slice.
// Pure declarations; no logic of its own.
package mfc_pkg;

  localparam int MFC_WORDS  = 24;
  localparam int MFC_DWIDTH = 21;
  localparam int MFC_AWIDTH = 5;
  localparam int MFC_OWIDTH = 16;
  localparam int MFC_SHIFT  = 4;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [31:0] val;
    logic               hit;
  } sat_t;

  // Clamp v into the signed range of an ow-bit word; hit flags a clamp.
  function automatic sat_t saturate(input logic signed [31:0] v, input int ow);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sat_t r;
    hi    = (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo    = -hi - 32'sd1;
    r.hit = 1'b1;
    if (v > hi) begin
      r.val = hi;
    end else if (v < lo) begin
      r.val = lo;
    end else begin
      r.val = v;
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mfc_mean_sub_if.sv
// mfc_mean_sub_if: feature-in / result-out streaming bundle.
// Ports: in_valid/in_ready/in_data (features), out_valid/out_ready/out_data/out_last (results).
// master = producer of features and consumer of results; slave = the mean-sub block.
interface mfc_mean_sub_if import mfc_pkg::*; #(
  parameter int DWIDTH = MFC_DWIDTH,
  parameter int OWIDTH = MFC_OWIDTH
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DWIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OWIDTH-1:0] out_data;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mfc_sat_shift.sv
// mfc_sat_shift: arithmetic right shift of the difference, then clamp to OWIDTH.
// Latency: combinational. Backpressure: none (pure function).
// Ports: diff (DWIDTH+1 signed) in; sh (OWIDTH signed) and clamp flag out.
module mfc_sat_shift import mfc_pkg::*; #(
  parameter int DWIDTH = MFC_DWIDTH,
  parameter int OWIDTH = MFC_OWIDTH,
  parameter int SHIFT  = MFC_SHIFT
) (
  input  logic signed [DWIDTH:0]   diff,
  output logic signed [OWIDTH-1:0] sh,
  output logic                     clamp
);
  logic signed [DWIDTH:0] shifted;
  logic signed [31:0]     shifted_ext;
  sat_t                   sat;
  logic                   unused_hi;

  // >>> on a signed operand rounds toward minus infinity.
  assign shifted     = diff >>> SHIFT;
  assign shifted_ext = 32'(shifted);
  assign sat         = saturate(shifted_ext, OWIDTH);
  assign sh          = sat.val[OWIDTH-1:0];
  assign clamp       = sat.hit;
  // Upper bits are a pure sign extension of sh after clamping.
  assign unused_hi   = ^sat.val[31:OWIDTH];
endmodule

// File: rtl/mfc_mean_sub.sv
// mfc_mean_sub: (feature - table constant) >>> SHIFT, saturated, per 24-word frame;
// also reloads the external coefficient table between frames.
// Latency: 2 register stages (stage 1 + output register). Backpressure: the whole
// pipeline stalls when out_valid && !out_ready; in_ready drops with it.
// Ports: clk/rst, st (stream bundle), ld_* (reload), tbl_* (table RAM port), ovf.
module mfc_mean_sub import mfc_pkg::*; #(
  parameter int DWIDTH = MFC_DWIDTH,
  parameter int AWIDTH = MFC_AWIDTH,
  parameter int WORDS  = MFC_WORDS,
  parameter int OWIDTH = MFC_OWIDTH,
  parameter int SHIFT  = MFC_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  mfc_mean_sub_if.slave            st,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic signed [DWIDTH-1:0] ld_data,
  output logic                     tbl_write,
  output logic [AWIDTH-1:0]        tbl_addr,
  output logic signed [DWIDTH-1:0] tbl_indata,
  input  logic signed [DWIDTH-1:0] tbl_outdata,
  output logic                     ovf
);
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(WORDS - 1);

  state_t                   state, state_nxt;
  logic [AWIDTH-1:0]        idx, lidx, s1_idx;
  logic                     ld_pend, s1_valid, en, in_rdy, in_fire, ld_done, clamp;
  logic signed [DWIDTH-1:0] s1_data;
  logic signed [DWIDTH:0]   diff;
  logic signed [OWIDTH-1:0] sh;
  logic                     out_valid_q, out_last_q;
  logic signed [OWIDTH-1:0] out_data_q;

  assign en           = !out_valid_q || st.out_ready;
  assign in_fire      = st.in_valid && in_rdy;
  assign st.in_ready  = in_rdy;
  assign st.out_valid = out_valid_q;
  assign st.out_data  = out_data_q;
  assign st.out_last  = out_last_q;

  // tbl_outdata lines up with stage 1 because the table read was issued
  // with the same address on the edge that loaded stage 1.
  assign diff = {s1_data[DWIDTH-1], s1_data} - {tbl_outdata[DWIDTH-1], tbl_outdata};

  mfc_sat_shift #(.DWIDTH(DWIDTH), .OWIDTH(OWIDTH), .SHIFT(SHIFT)) u_sat (
    .diff  (diff),
    .sh    (sh),
    .clamp (clamp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_rdy     = 1'b0;
    ld_ready   = 1'b0;
    tbl_write  = 1'b0;
    tbl_indata = '0;
    ld_done    = 1'b0;
    // While stalled, keep re-reading the constant of the word held in stage 1.
    tbl_addr   = en ? idx : s1_idx;
    case (state)
      RUN: begin
        // A pending reload holds off the next frame at its first word.
        in_rdy = en && !(ld_pend && idx == '0);
        if (ld_pend && idx == '0 && !s1_valid && !out_valid_q) state_nxt = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        tbl_addr = lidx;
        if (ld_valid) begin
          tbl_write  = 1'b1;
          tbl_indata = ld_data;
          if (lidx == LAST) begin
            ld_done   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      lidx        <= '0;
      ld_pend     <= 1'b0;
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_idx      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (in_fire) idx <= (idx == LAST) ? '0 : idx + 1'b1;

      if (ld_done) begin
        lidx    <= '0;
        ld_pend <= 1'b0;
      end else begin
        if (tbl_write) lidx <= lidx + 1'b1;
        if (ld_start)  ld_pend <= 1'b1;
      end

      if (en) begin
        s1_valid    <= in_fire;
        s1_data     <= st.in_data;
        s1_idx      <= idx;
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          out_data_q <= sh;
          out_last_q <= (s1_idx == LAST);
          ovf        <= ovf | clamp;
        end
      end
    end
  end
endmodule

// File: tb/tb_mfc_mean_sub.sv
module tb_mfc_mean_sub;
  localparam int DW = 21;
  localparam int AW = 5;
  localparam int NW = 24;
  localparam int OW = 16;
  localparam int SH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mfc_mean_sub_if #(.DWIDTH(DW), .OWIDTH(OW)) bus ();

  logic                 ld_start = 1'b0;
  logic                 ld_valid = 1'b0;
  logic signed [DW-1:0] ld_data  = '0;
  logic                 ld_ready, tbl_write, ovf;
  logic [AW-1:0]        tbl_addr;
  logic signed [DW-1:0] tbl_indata, tbl_outdata;

  mfc_mean_sub #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(NW), .OWIDTH(OW), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .st(bus),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .tbl_write(tbl_write), .tbl_addr(tbl_addr), .tbl_indata(tbl_indata),
    .tbl_outdata(tbl_outdata), .ovf(ovf)
  );

  // Coefficient table RAM: registered read, 1-cycle latency.
  logic signed [DW-1:0] ram [32];
  logic init_tbl = 1'b0;
  always @(posedge clk) begin
    if (init_tbl) begin
      for (int i = 0; i < NW; i++) ram[i] <= DW'(def_tbl(i));
    end else if (tbl_write) begin
      ram[tbl_addr] <= tbl_indata;
    end
    tbl_outdata <= ram[tbl_addr];
  end

  // ---------------- reference model ----------------
  int model_tbl[NW];

  function automatic int def_tbl(input int i);
    return 241930 - i * 20000;
  endfunction

  // floor((w - c) / 2^SH), clamped to the OW-bit signed range.
  function automatic int ref_out(input int w, input int c, output bit hit);
    int d, q, div, hi, lo;
    div = 1 << SH;
    hi  = (1 << (OW - 1)) - 1;
    lo  = -(1 << (OW - 1));
    d   = w - c;
    q   = d / div;
    if ((d % div) != 0 && d < 0) q = q - 1;
    hit = 1'b1;
    if (q > hi) q = hi;
    else if (q < lo) q = lo;
    else hit = 1'b0;
    return q;
  endfunction

  function automatic int gen_word(input int k);
    int w;
    if ($urandom_range(0, 3) == 0) w = int'($urandom_range(0, 2097151)) - 1048576;
    else w = model_tbl[k] + int'($urandom_range(0, 1000000)) - 500000;
    if (w > 1048575) w = 1048575;
    if (w < -1048576) w = -1048576;
    return w;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  typedef struct { int data; bit last; } exp_t;
  exp_t sb[$];
  bit   mon_en  = 1'b0;
  int   mon_k   = 0;
  bit   mon_ovf = 1'b0;
  int   n_out   = 0;
  bit   held    = 1'b0;
  int   held_data;
  bit   held_last;

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   hit;
    if (rst) begin
      sb.delete();
      mon_k   = 0;
      mon_ovf = 1'b0;
      held    = 1'b0;
    end else if (mon_en) begin
      if (held) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, held_data);
        chk("hold_last", bus.out_last, held_last);
      end
      held = bus.out_valid && !bus.out_ready;
      if (held) begin
        held_data = bus.out_data;
        held_last = bus.out_last;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data %0d, expected no output", bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_last", bus.out_last, e.last);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.data  = ref_out(int'(bus.in_data), model_tbl[mon_k], hit);
        e.last  = (mon_k == NW - 1);
        mon_ovf = mon_ovf | hit;
        sb.push_back(e);
        mon_k   = (mon_k + 1) % NW;
      end
    end
  end

  // ---------------- drivers ----------------
  bit rand_rdy = 1'b0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  int feed_q[$];

  // Offer feed_q words with pv% valid probability; pulse ld_start when word ld_at is offered.
  task automatic feed(input int ld_at, input int pv);
    int acc = 0;
    int guard = 0;
    bit hs;
    bit sent = 1'b0;
    while (feed_q.size() > 0 && guard < 3000) begin
      bus.in_valid = ($urandom_range(0, 99) < pv);
      bus.in_data  = DW'(feed_q[0]);
      ld_start     = (acc == ld_at) && !sent && bus.in_valid;
      if (ld_start) sent = 1'b1;
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      ld_start = 1'b0;
      if (hs) begin
        void'(feed_q.pop_front());
        acc++;
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("feed_done_words_left", feed_q.size(), 0);
    feed_q.delete();
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 300) begin
      tick();
      g++;
    end
    tick();
    tick();
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string t);
    chk({t, "_out_valid"}, bus.out_valid, 0);
    chk({t, "_out_data"}, bus.out_data, 0);
    chk({t, "_out_last"}, bus.out_last, 0);
    chk({t, "_ovf"}, ovf, 0);
    chk({t, "_ld_ready"}, ld_ready, 0);
    chk({t, "_tbl_write"}, tbl_write, 0);
    chk({t, "_tbl_addr"}, tbl_addr, 0);
    chk({t, "_tbl_indata"}, tbl_indata, 0);
    chk({t, "_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  typedef struct { int word; int exp_data; bit exp_ovf; } vec_t;
  vec_t vecs[10];

  initial begin
    bit leak, run_wr, started, wrote;
    int wr, g;

    vecs[0] = '{242090, 10, 1'b0};
    vecs[1] = '{0, -15121, 1'b0};
    vecs[2] = '{1048575, 32767, 1'b1};
    vecs[3] = '{-1048576, -32768, 1'b1};
    vecs[4] = '{241898, -2, 1'b0};
    vecs[5] = '{241929, -1, 1'b0};
    vecs[6] = '{766202, 32767, 1'b0};
    vecs[7] = '{766218, 32767, 1'b1};
    vecs[8] = '{-282358, -32768, 1'b0};
    vecs[9] = '{-282359, -32768, 1'b1};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < NW; i++) model_tbl[i] = def_tbl(i);
    init_tbl = 1'b1;
    tick();
    init_tbl = 1'b0;
    check_reset("por");
    tick();
    rst = 1'b0;

    // Single word at index 0 after reset: value, 2-cycle latency, ovf stickiness.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(vecs[v].word);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", v), bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_early_valid", v), bus.out_valid, 0);
      tick();
      chk($sformatf("vec%0d_out_valid", v), bus.out_valid, 1);
      chk($sformatf("vec%0d_out_data", v), bus.out_data, vecs[v].exp_data);
      chk($sformatf("vec%0d_out_last", v), bus.out_last, 0);
      chk($sformatf("vec%0d_ovf", v), ovf, vecs[v].exp_ovf);
      if (vecs[v].exp_ovf) begin
        tick();
        tick();
        tick();
        chk($sformatf("vec%0d_ovf_sticky", v), ovf, 1);
      end
    end

    // Three random frames with random valid and ready.
    do_reset();
    rand_rdy = 1'b1;
    mon_en   = 1'b1;
    n_out    = 0;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < NW; k++) feed_q.push_back(gen_word(k));
    feed(-1, 70);
    drain();
    chk("rand_frames_count", n_out, 3 * NW);
    chk("rand_frames_ovf", ovf, mon_ovf);

    // Reload requested mid-frame (word 10): deferred to the frame boundary.
    do_reset();
    rand_rdy = 1'b0;
    n_out    = 0;
    for (int k = 0; k < NW; k++) feed_q.push_back(gen_word(k));
    feed(10, 100);
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    ld_valid = 1'b1;
    ld_data  = DW'(1000);
    leak = 1'b0; run_wr = 1'b0; started = 1'b0; wr = 0; g = 0;
    while (wr < NW && g < 200) begin
      @(negedge clk);
      leak  = leak | bus.in_ready;
      wrote = 1'b0;
      if (!ld_ready) begin
        run_wr = run_wr | tbl_write;
      end else begin
        started = 1'b1;
        if (ld_valid) begin
          chk($sformatf("ld_write_en%0d", wr), tbl_write, 1);
          chk($sformatf("ld_addr%0d", wr), tbl_addr, wr);
          chk($sformatf("ld_data%0d", wr), tbl_indata, 1000 + wr);
          wrote = 1'b1;
        end else begin
          chk("ld_idle_write", tbl_write, 0);
        end
      end
      @(posedge clk);
      #1;
      g++;
      if (wrote) wr++;
      ld_valid = (wr < NW) && (!started || $urandom_range(0, 2) != 0);
      ld_data  = DW'(1000 + wr);
    end
    bus.in_valid = 1'b0;
    ld_valid     = 1'b0;
    chk("ld_writes", wr, NW);
    chk("ld_input_blocked_leak", leak, 0);
    chk("ld_write_in_run", run_wr, 0);
    chk("ld_frame_outputs", n_out, NW);
    @(negedge clk);
    chk("ld_exit_ready", ld_ready, 0);
    chk("ld_exit_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < NW; i++) model_tbl[i] = 1000 + i;

    // Frame matching the new table: every output should be zero.
    rand_rdy = 1'b1;
    n_out    = 0;
    for (int k = 0; k < NW; k++) feed_q.push_back(1000 + k);
    feed(-1, 80);
    drain();
    chk("zero_frame_count", n_out, NW);

    // Reset during LOAD at lidx=5: earlier writes persist, idx restarts.
    rand_rdy = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    g = 0;
    while (!ld_ready && g < 20) begin
      tick();
      g++;
    end
    chk("rstload_enter", ld_ready, 1);
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(5000 + i);
      #1;
      chk($sformatf("rstload_addr%0d", i), tbl_addr, i);
      @(posedge clk);
      #1;
    end
    ld_data = DW'(5005);
    #2;
    rst = 1'b1;
    #1;
    check_reset("rst_load");
    ld_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) model_tbl[i] = 5000 + i;
    rand_rdy = 1'b1;
    n_out    = 0;
    for (int k = 0; k < NW; k++) feed_q.push_back(gen_word(k));
    feed(-1, 75);
    drain();
    chk("after_rstload_count", n_out, NW);

    // Reset mid-frame after 7 words.
    for (int k = 0; k < 7; k++) feed_q.push_back(gen_word(k));
    feed(-1, 100);
    #2;
    rst = 1'b1;
    #1;
    check_reset("rst_frame");
    @(posedge clk);
    #1;
    rst   = 1'b0;
    n_out = 0;
    for (int k = 0; k < NW; k++) feed_q.push_back(gen_word(k));
    feed(-1, 75);
    drain();
    chk("after_rstframe_count", n_out, NW);
    chk("final_ovf", ovf, mon_ovf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
